// File: rtl/lcd_spi_decoder_pkg.sv
// lcd_spi_pkg: shared types, LCD command opcodes and default widths for the
// LCD serial-bus decoder.
package lcd_spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
    } byte_rec_t;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_INVON   = 8'h21;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;
    localparam logic [7:0] CMD_FRMCTR1 = 8'hB1;

    localparam int PIDX_W_DEF = 14;
    localparam int ERRC_W_DEF = 8;

endpackage

// File: rtl/lcd_spi_decoder_in_sync.sv
// lcd_spi_in_sync: bus input sampling and SCL rise detect; LCD_DEC_SYNC_EN
// inserts a 2-flop synchronizer ahead of the sampling stage.
module lcd_spi_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic cs,
    input  logic dc,
    input  logic mosi,
    output logic scl_rise,
    output logic cs_s,
    output logic dc_s,
    output logic mosi_s
);
    logic [3:0] smp_d, smp_q;
    logic       scl_prev_d, scl_prev_q;
`ifdef LCD_DEC_SYNC_EN
    logic [3:0] meta_d, meta_q, sync_d, sync_q;
    always_comb begin
        meta_d = {scl, cs, dc, mosi};
        sync_d = meta_q;
        smp_d  = sync_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end
`else
    always_comb smp_d = {scl, cs, dc, mosi};
`endif
    always_comb scl_prev_d = smp_q[3];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q      <= '0;
            scl_prev_q <= 1'b0;
        end else begin
            smp_q      <= smp_d;
            scl_prev_q <= scl_prev_d;
        end
    end
    assign scl_rise               = smp_q[3] & ~scl_prev_q;
    assign {cs_s, dc_s, mosi_s}   = smp_q[2:0];
endmodule

// File: rtl/lcd_spi_decoder.sv
// lcd_spi_decoder: passive LCD 4-wire serial bus decoder (bytes, DC tag,
// parameter index, frame errors). Define LCD_DEC_SYNC_EN for async inputs.
module lcd_spi_decoder
    import lcd_spi_pkg::*;
#(
    parameter int PIDX_W = PIDX_W_DEF,
    parameter int ERRC_W = ERRC_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              SCL,
    input  logic              MOSI,
    input  logic              CS,
    input  logic              DC,
    output logic [7:0]        BYTE_DATA,
    output logic              BYTE_DC,
    output logic              BYTE_VALID,
    output logic [PIDX_W-1:0] PARAM_IDX,
    output logic [7:0]        LAST_CMD,
    output logic              FRAME_ERR,
    output logic [ERRC_W-1:0] ERR_COUNT,
    output logic              BUSY
);
    logic scl_rise, cs_s, dc_s, mosi_s;

    lcd_spi_in_sync u_in_sync (
        .clk      (CLK),
        .rst_n    (RST_N),
        .scl      (SCL),
        .cs       (CS),
        .dc       (DC),
        .mosi     (MOSI),
        .scl_rise (scl_rise),
        .cs_s     (cs_s),
        .dc_s     (dc_s),
        .mosi_s   (mosi_s)
    );

    state_t            state_d, state_q;
    logic [2:0]        bit_cnt_d, bit_cnt_q;
    logic [7:0]        sr_d, sr_q;
    logic              done_d, done_q;
    byte_rec_t         done_rec_d, done_rec_q;
    logic              frame_err_d, frame_err_q;
    logic [ERRC_W-1:0] err_count_d, err_count_q;
    logic [7:0]        byte_data_d, byte_data_q;
    logic              byte_dc_d, byte_dc_q;
    logic              byte_valid_d, byte_valid_q;
    logic [PIDX_W-1:0] param_idx_d, param_idx_q;
    logic [PIDX_W-1:0] pcnt_d, pcnt_q;
    logic [7:0]        last_cmd_d, last_cmd_q;
    logic              busy_d, busy_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        done_d      = 1'b0;
        done_rec_d  = done_rec_q;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;
        if (state_q == IDLE) begin
            bit_cnt_d = '0;
            state_d   = cs_s ? IDLE : SHIFT;
        end else begin
            if (scl_rise) begin
                sr_d      = {sr_q[6:0], mosi_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
                done_d    = (bit_cnt_q == 3'd7);
                if (done_d) begin
                    done_rec_d.data = sr_d;
                    done_rec_d.dc   = dc_s;
                end
            end
            // The frame check sees the bit count after any same-sample rise.
            if (cs_s) begin
                state_d     = IDLE;
                frame_err_d = (bit_cnt_d != 3'd0);
                if (frame_err_d && !(&err_count_q))
                    err_count_d = err_count_q + ERRC_W'(1);
                bit_cnt_d   = '0;
            end
        end
    end

    always_comb begin
        byte_valid_d = done_q;
        byte_data_d  = done_q ? done_rec_q.data : byte_data_q;
        byte_dc_d    = done_q ? done_rec_q.dc : byte_dc_q;
        param_idx_d  = !done_q ? param_idx_q : (done_rec_q.dc ? pcnt_q : '0);
        last_cmd_d   = (done_q && !done_rec_q.dc) ? done_rec_q.data : last_cmd_q;
        pcnt_d       = !done_q ? pcnt_q :
                       !done_rec_q.dc ? '0 :
                       (&pcnt_q) ? pcnt_q : pcnt_q + PIDX_W'(1);
        busy_d       = ~cs_s;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            sr_q         <= '0;
            done_q       <= 1'b0;
            done_rec_q   <= '0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
            byte_data_q  <= '0;
            byte_dc_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            param_idx_q  <= '0;
            pcnt_q       <= '0;
            last_cmd_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sr_q         <= sr_d;
            done_q       <= done_d;
            done_rec_q   <= done_rec_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
            byte_data_q  <= byte_data_d;
            byte_dc_q    <= byte_dc_d;
            byte_valid_q <= byte_valid_d;
            param_idx_q  <= param_idx_d;
            pcnt_q       <= pcnt_d;
            last_cmd_q   <= last_cmd_d;
            busy_q       <= busy_d;
        end
    end

    assign BYTE_DATA  = byte_data_q;
    assign BYTE_DC    = byte_dc_q;
    assign BYTE_VALID = byte_valid_q;
    assign PARAM_IDX  = param_idx_q;
    assign LAST_CMD   = last_cmd_q;
    assign FRAME_ERR  = frame_err_q;
    assign ERR_COUNT  = err_count_q;
    assign BUSY       = busy_q;
endmodule

// File: tb/tb_lcd_spi_decoder.sv
// tb_lcd_spi_decoder: table-driven, hand-sequenced and randomized checks of
// lcd_spi_decoder against a byte-level reference model.
module tb_lcd_spi_decoder;
    import lcd_spi_pkg::*;

`ifdef LCD_DEC_SYNC_EN
    localparam int HALF = 2;
    localparam int LAT  = 3;
`else
    localparam int HALF = 1;
    localparam int LAT  = 1;
`endif
    localparam int PMAX = (1 << 14) - 1;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        SCL = 1'b0;
    logic        MOSI = 1'b0;
    logic        CS = 1'b1;
    logic        DC = 1'b0;
    logic [7:0]  BYTE_DATA;
    logic        BYTE_DC;
    logic        BYTE_VALID;
    logic [13:0] PARAM_IDX;
    logic [7:0]  LAST_CMD;
    logic        FRAME_ERR;
    logic [7:0]  ERR_COUNT;
    logic        BUSY;

    lcd_spi_decoder dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SCL        (SCL),
        .MOSI       (MOSI),
        .CS         (CS),
        .DC         (DC),
        .BYTE_DATA  (BYTE_DATA),
        .BYTE_DC    (BYTE_DC),
        .BYTE_VALID (BYTE_VALID),
        .PARAM_IDX  (PARAM_IDX),
        .LAST_CMD   (LAST_CMD),
        .FRAME_ERR  (FRAME_ERR),
        .ERR_COUNT  (ERR_COUNT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]  d;
        logic        dc;
        logic [13:0] idx;
        logic [7:0]  last;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        int         nbits;
        bit         lo;
        bit         hi;
        bit         coinc;
        logic [7:0] e_last;
        int         e_idx;
        int         e_err;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   t_rise = 0;
    int   fe_seen = 0;
    int   wide = 0;
    logic bv_prev = 1'b0;
    ev_t  got[$];
    int   vcyc[$];
    int   rd = 0;
    int   fe_rd = 0;

    logic [7:0] m_last = 8'h00;
    int         m_pcnt = 0;
    int         m_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST_N && BYTE_VALID) begin
            got.push_back({BYTE_DATA, BYTE_DC, PARAM_IDX, LAST_CMD});
            vcyc.push_back(cyc);
        end
        if (RST_N && FRAME_ERR) fe_seen++;
        if (BYTE_VALID && bv_prev) wide++;
        bv_prev = BYTE_VALID;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish, got=%0d expected=done", vectors);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] d, input logic dcv, output int idx);
        if (!dcv) begin
            m_last = d;
            m_pcnt = 0;
            idx    = 0;
        end else begin
            idx = m_pcnt;
            if (m_pcnt < PMAX) m_pcnt++;
        end
    endtask

    task automatic cs_low();
        CS = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dcv, input int nbits,
                             input bit coinc, input bit noise);
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[7-i];
            DC   = (noise && i != 7) ? 1'($urandom_range(0, 1)) : dcv;
            repeat (HALF) @(negedge CLK);
            SCL    = 1'b1;
            t_rise = cyc;
            if (coinc && i == 7) CS = 1'b1;
            repeat (HALF) @(negedge CLK);
            SCL = 1'b0;
        end
    endtask

    task automatic check_frame(input string nm, input bit full, input bit hi,
                               input logic [7:0] ed, input logic edc, input int eidx,
                               input logic [7:0] elast, input int eerr);
        check({nm, ":nbytes"}, 32'(got.size() - rd), full ? 32'd1 : 32'd0);
        if (full && got.size() > rd) begin
            check({nm, ":data"}, 32'(got[rd].d), 32'(ed));
            check({nm, ":dc"}, 32'(got[rd].dc), 32'(edc));
            check({nm, ":idx"}, 32'(got[rd].idx), 32'(eidx));
            check({nm, ":last"}, 32'(got[rd].last), 32'(elast));
        end
        rd = got.size();
        check({nm, ":frame_err"}, 32'(fe_seen - fe_rd), (!full && hi) ? 32'd1 : 32'd0);
        fe_rd = fe_seen;
        check({nm, ":err_count"}, 32'(ERR_COUNT), 32'(eerr));
        check({nm, ":busy"}, 32'(BUSY), hi ? 32'd0 : 32'd1);
    endtask

    vec_t tbl[13];

    initial begin
        int         eidx, nb, base;
        bit         hi, co;
        logic [7:0] d;
        logic       dcv;

        tbl[0]  = '{8'h55,       1'b1, 8, 1'b1, 1'b1, 1'b0, 8'h00,       0, 0};
        tbl[1]  = '{CMD_FRMCTR1, 1'b0, 8, 1'b1, 1'b1, 1'b0, CMD_FRMCTR1, 0, 0};
        tbl[2]  = '{8'h05,       1'b1, 8, 1'b1, 1'b1, 1'b0, CMD_FRMCTR1, 0, 0};
        tbl[3]  = '{8'h3C,       1'b1, 8, 1'b1, 1'b1, 1'b0, CMD_FRMCTR1, 1, 0};
        tbl[4]  = '{8'h3C,       1'b1, 8, 1'b1, 1'b1, 1'b0, CMD_FRMCTR1, 2, 0};
        tbl[5]  = '{CMD_RAMWR,   1'b0, 8, 1'b1, 1'b0, 1'b0, CMD_RAMWR,   0, 0};
        tbl[6]  = '{8'hFF,       1'b1, 8, 1'b0, 1'b0, 1'b0, CMD_RAMWR,   0, 0};
        tbl[7]  = '{8'h00,       1'b1, 8, 1'b0, 1'b0, 1'b0, CMD_RAMWR,   1, 0};
        tbl[8]  = '{8'hAA,       1'b1, 8, 1'b0, 1'b1, 1'b0, CMD_RAMWR,   2, 0};
        tbl[9]  = '{CMD_COLMOD,  1'b0, 5, 1'b1, 1'b1, 1'b0, CMD_RAMWR,   0, 1};
        tbl[10] = '{CMD_COLMOD,  1'b0, 8, 1'b1, 1'b1, 1'b0, CMD_COLMOD,  0, 1};
        tbl[11] = '{8'h05,       1'b1, 8, 1'b1, 1'b1, 1'b1, CMD_COLMOD,  0, 1};
        tbl[12] = '{CMD_NOP,     1'b0, 8, 1'b1, 1'b1, 1'b0, CMD_NOP,     0, 1};

        repeat (3) @(negedge CLK);
        check("rst:data", 32'(BYTE_DATA), 32'd0);
        check("rst:valid", 32'(BYTE_VALID), 32'd0);
        check("rst:idx", 32'(PARAM_IDX), 32'd0);
        check("rst:last", 32'(LAST_CMD), 32'd0);
        check("rst:err", 32'({FRAME_ERR, ERR_COUNT}), 32'd0);
        check("rst:busy", 32'(BUSY), 32'd0);
        RST_N = 1'b1;
        repeat (6) @(negedge CLK);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].lo) cs_low();
            send_bits(tbl[i].data, tbl[i].dc, tbl[i].nbits, tbl[i].coinc, 1'b0);
            if (tbl[i].hi && !tbl[i].coinc) CS = 1'b1;
            repeat (10) @(negedge CLK);
            check_frame($sformatf("tbl%0d", i), tbl[i].nbits == 8, tbl[i].hi, tbl[i].data,
                        tbl[i].dc, tbl[i].e_idx, tbl[i].e_last, tbl[i].e_err);
        end
        m_last = CMD_NOP;
        m_pcnt = 0;
        m_err  = 1;

        // Back-to-back burst under one CS window: pulses exactly 8 SCL periods apart.
        base = got.size();
        cs_low();
        send_bits(CMD_RAMWR, 1'b0, 8, 1'b0, 1'b0);
        send_bits(8'hFF, 1'b1, 8, 1'b0, 1'b0);
        send_bits(8'h00, 1'b1, 8, 1'b0, 1'b0);
        send_bits(8'hAA, 1'b1, 8, 1'b0, 1'b0);
        CS = 1'b1;
        repeat (10) @(negedge CLK);
        check("burst:nbytes", 32'(got.size() - base), 32'd4);
        for (int j = 0; j < 4; j++) begin
            d   = (j == 0) ? CMD_RAMWR : (j == 1) ? 8'hFF : (j == 2) ? 8'h00 : 8'hAA;
            dcv = (j != 0);
            model_byte(d, dcv, eidx);
            if (got.size() > base + j) begin
                check($sformatf("burst%0d:data", j), 32'(got[base+j].d), 32'(d));
                check($sformatf("burst%0d:idx", j), 32'(got[base+j].idx), 32'(eidx));
                if (j > 0)
                    check($sformatf("burst%0d:spacing", j),
                          32'(vcyc[base+j] - vcyc[base+j-1]), 32'(16 * HALF));
            end
        end
        rd = got.size();
        fe_rd = fe_seen;

        // D-to-BYTE_VALID latency: SCL set before capture edge, detect one edge later.
        cs_low();
        send_bits(8'hA5, 1'b1, 8, 1'b0, 1'b0);
        CS = 1'b1;
        repeat (10) @(negedge CLK);
        if (got.size() > rd)
            check("latency", 32'(vcyc[got.size()-1] - t_rise - 2), 32'(LAT));
        else
            check("latency:nbytes", 32'(got.size() - rd), 32'd1);
        model_byte(8'hA5, 1'b1, eidx);
        check_frame("latency", 1'b1, 1'b1, 8'hA5, 1'b1, eidx, m_last, m_err);

        for (int k = 0; k < 40; k++) begin
            nb  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
            hi  = (nb != 8) || ($urandom_range(0, 1) == 1);
            co  = (nb == 8) && hi && ($urandom_range(0, 1) == 1);
            d   = 8'($urandom);
            dcv = 1'($urandom_range(0, 1));
            if (CS) cs_low();
            send_bits(d, dcv, nb, co, 1'b1);
            if (hi && !co) CS = 1'b1;
            repeat (10) @(negedge CLK);
            eidx = 0;
            if (nb == 8) model_byte(d, dcv, eidx);
            else if (m_err < 255) m_err++;
            check_frame($sformatf("rnd%0d", k), nb == 8, hi, d, dcv, eidx, m_last, m_err);
        end

        base = fe_seen;
        for (int k = 0; k < 300; k++) begin
            cs_low();
            send_bits(8'hE0, 1'b1, 3, 1'b0, 1'b0);
            CS = 1'b1;
            repeat (6) @(negedge CLK);
        end
        check("sat:pulses", 32'(fe_seen - base), 32'd300);
        check("sat:err_count", 32'(ERR_COUNT), 32'd255);
        fe_rd = fe_seen;
        rd = got.size();

        cs_low();
        send_bits(8'hC3, 1'b1, 4, 1'b0, 1'b0);
        RST_N = 1'b0;
        #1;
        check("rst_mid:data", 32'(BYTE_DATA), 32'd0);
        check("rst_mid:idx", 32'(PARAM_IDX), 32'd0);
        check("rst_mid:last", 32'(LAST_CMD), 32'd0);
        check("rst_mid:err_count", 32'(ERR_COUNT), 32'd0);
        check("rst_mid:busy_valid_fe", 32'({BUSY, BYTE_VALID, FRAME_ERR, BYTE_DC}), 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        m_last = 8'h00;
        m_pcnt = 0;
        m_err  = 0;
        fe_rd  = fe_seen;
        rd     = got.size();
        repeat (3) @(negedge CLK);
        send_bits(8'h77, 1'b1, 8, 1'b0, 1'b0);
        CS = 1'b1;
        repeat (10) @(negedge CLK);
        model_byte(8'h77, 1'b1, eidx);
        check_frame("rst_mid", 1'b1, 1'b1, 8'h77, 1'b1, eidx, m_last, m_err);

        check("valid_width", 32'(wide), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lcd_spi_decoder.md
Name: lcd_spi_decoder

Overview:
Passive receive-side decoder for the 4-wire write-only LCD serial bus (SCL, MOSI, CS, DC) that our LCD init/draw sequencer drives. It oversamples the bus with the system clock and reassembles bytes MSB-first. Each byte is tagged as command or parameter, and parameters are indexed relative to the last command. It serves as an on-chip bus monitor/loopback checker and as the front end of a future LCD emulator.

Parameters:
PIDX_W, 14, width of parameter index counter (covers 12800-byte RAMWR bursts)
ERRC_W, 8, width of saturating frame-error counter

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
SCL  in  1  serial clock from bus master; data valid on rising edge
MOSI  in  1  serial data, MSB first
CS  in  1  chip select, active low
DC  in  1  0 = command byte, 1 = parameter/data byte
BYTE_DATA  out  8  last completed byte
BYTE_DC  out  1  DC value sampled at that byte's 8th SCL rise
BYTE_VALID  out  1  one-CLK pulse per completed byte
PARAM_IDX  out  PIDX_W  0 for command bytes; n-th parameter since last command (0-based) for DC=1
LAST_CMD  out  8  most recent command byte
FRAME_ERR  out  1  one-CLK pulse: CS deasserted with a partial byte
ERR_COUNT  out  ERRC_W  saturating count of FRAME_ERR events
BUSY  out  1  registered copy of sampled CS low

Behaviour:
- Clock/reset: one clock, CLK. RST_N is asynchronous and active-low. All outputs and internal state reset to 0.
- Sampling: SCL, CS, DC and MOSI are registered once per CLK into scl_q, cs_q, dc_q, mosi_q. scl_prev holds the previous scl_q. A rise is scl_q & ~scl_prev.
- The minimum supported SCL period is 2 CLK (high 1, low 1), which is the sequencer's rate.
- States:
  - IDLE: cs_q high. Bit counter is held at 0 and SCL rises are ignored. cs_q low moves to SHIFT; bit counter is 0 on entry.
  - SHIFT: on each rise, shift mosi_q into sr[0] (sr shifts left) and increment bit_cnt (3 bits).
    - On the rise that completes bit 7, the byte is latched together with dc_q and bit_cnt wraps to 0.
    - Further bytes may follow under the same CS-low window; there is no gap requirement beyond the SCL period.
  - cs_q high while in SHIFT returns to IDLE. If bit_cnt != 0, FRAME_ERR pulses, the partial byte is discarded and ERR_COUNT increments, saturating at all-ones.
- Byte latency: the 8th rise is detected at CLK edge D. BYTE_DATA, BYTE_DC, PARAM_IDX and LAST_CMD update at edge D+1, and BYTE_VALID is high for exactly the cycle following D+1. Outputs hold their values until the next byte.
- Index rules:
  - Byte with DC=0: PARAM_IDX=0, LAST_CMD=byte, internal param counter := 0.
  - Byte with DC=1: PARAM_IDX = counter, then counter +1, saturating at all-ones. PARAM_IDX then holds the max value for every subsequent parameter.
  - Parameters before any command: LAST_CMD stays 0x00 and indexing proceeds from 0.
  - NOP (0x00) is decoded like any other command.
- Simultaneous events: SCL rise and CS rise in the same sample apply the rise first, then the frame check uses the updated bit_cnt. A rise completing bit 7 together with CS high yields BYTE_VALID and no FRAME_ERR.
- DC changes mid-byte are not errors; only DC at the 8th rise matters.
- Reset mid-byte: partial data is discarded, no FRAME_ERR, and counters are cleared.

Optional Feature:
LCD_DEC_SYNC_EN:
- Defined: each input passes through a 2-flop synchronizer before the sampling stage, so the block is safe for off-chip/asynchronous buses. Byte latency grows by 2 CLK, and SCL high and low must each be >=2 CLK.
- Undefined: single register stage only; inputs must be synchronous to CLK (same-chip loopback from the sequencer).

Decomposition:
- Package lcd_spi_pkg:
  - State enum {IDLE, SHIFT}.
  - Command opcode constants: CMD_NOP 8'h00, CMD_INVON 8'h21, CMD_DISPON 8'h29, CMD_CASET 8'h2A, CMD_RASET 8'h2B, CMD_RAMWR 8'h2C, CMD_MADCTL 8'h36, CMD_COLMOD 8'h3A, CMD_FRMCTR1 8'hB1.
  - Default widths.
- Sub-module lcd_spi_in_sync: input registration, optional synchronizer, and SCL rise detect. It outputs scl_rise, cs_s, dc_s, mosi_s.

Test Plan:
- Command framing: CS low, DC=0, shift 0xB1, CS high. Then three separate CS frames with DC=1 carrying 0x05, 0x3C, 0x3C -> four BYTE_VALID pulses; BYTE_DC 0,1,1,1; PARAM_IDX 0,0,1,2; LAST_CMD=0xB1; FRAME_ERR never asserted.
- Burst under one CS: 0x2C as command, then 0xFF,0x00,0xAA without raising CS -> PARAM_IDX 0,1,2; BYTE_DATA 0xFF,0x00,0xAA; one-cycle pulses spaced exactly 8 SCL periods apart.
- Partial frame: CS low, 5 bits of 0x3A, CS high -> FRAME_ERR one pulse, ERR_COUNT=1, no BYTE_VALID. A following full 0x3A decodes correctly.
- Edge cases:
  - Parameter 0x55 sent before any command -> LAST_CMD=0x00, PARAM_IDX=0.
  - 8th rise coincident with CS rise -> BYTE_VALID, no FRAME_ERR.
- Saturation/reset:
  - 300 frame errors -> ERR_COUNT stays 255.
  - RST_N pulsed low mid-byte -> all outputs 0 immediately, and the next full byte decodes with PARAM_IDX=0.
- Timing: SCL at CLK/2 (sequencer rate) with a fixed byte. Measure D-to-BYTE_VALID latency: 1 CLK without LCD_DEC_SYNC_EN, 3 CLK with it (SCL period 4 CLK).
